// File: rtl/rv_clint_pkg.sv
// Shared CLINT register offsets, bus FSM encodings and the address decoder.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package rv_clint_pkg;

    localparam logic [15:0] MSIP_OFS        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFS = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFS = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFS    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFS    = 16'hBFFC;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    // All offsets are word aligned, so a misaligned address can never match.
    function automatic reg_sel_e decode_addr(input logic [15:0] addr);
        case (addr)
            MSIP_OFS:        return REG_MSIP;
            MTIMECMP_LO_OFS: return REG_CMP_LO;
            MTIMECMP_HI_OFS: return REG_CMP_HI;
            MTIME_LO_OFS:    return REG_MTIME_LO;
            MTIME_HI_OFS:    return REG_MTIME_HI;
            default:         return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv_clint_timer.sv
// 64-bit mtime counter advanced once per TICK_DIV clk cycles, loadable per 32-bit half.
// Latency: loads and increments take effect at the next clk edge.
// Backpressure: none; a load wins over a same-cycle increment and restarts the prescaler.
module rv_clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_dat,
    output logic [63:0] mtime
);

    logic [15:0] presc;
    logic        wrap;

    assign wrap = (presc == 16'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
            mtime <= '0;
        end else if (load_lo || load_hi) begin
            presc <= '0;
            if (load_lo) mtime[31:0]  <= load_dat;
            if (load_hi) mtime[63:32] <= load_dat;
        end else if (wrap) begin
            presc <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

endmodule

// File: rtl/rv_clint.sv
// CLINT: msip, mtimecmp and mtime behind a req/ack register bus, driving soft and timer irqs.
// Latency: ack_o one cycle after req_i is sampled; timer_irq_o one cycle after the compare holds.
// Backpressure: none; req_i is ignored during the response cycle, so accesses are >= 2 cycles apart.
module rv_clint
    import rv_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        soft_irq_o,
    output logic        timer_irq_o
);

    logic [0:0]  state;
    reg_sel_e    sel;
    logic        bad;
    logic        wr;
    logic        msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] rd_mux;

    assign sel        = decode_addr(addr_i);
    assign bad        = (sel == REG_NONE);
    assign wr         = (state == ST_IDLE) && req_i && we_i;
    assign soft_irq_o = msip;

    rv_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load_lo  (wr && (sel == REG_MTIME_LO)),
        .load_hi  (wr && (sel == REG_MTIME_HI)),
        .load_dat (wdata_i),
        .mtime    (mtime)
    );

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_MSIP:     rd_mux = {31'd0, msip};
            REG_CMP_LO:   rd_mux = mtimecmp[31:0];
            REG_CMP_HI:   rd_mux = mtimecmp[63:32];
            REG_MTIME_LO: rd_mux = mtime[31:0];
            REG_MTIME_HI: rd_mux = mtime[63:32];
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else if (state == ST_IDLE) begin
            if (req_i) begin
                state   <= ST_RESP;
                ack_o   <= 1'b1;
                err_o   <= bad;
                rdata_o <= we_i ? 32'd0 : rd_mux;
            end
        end else begin
            state   <= ST_IDLE;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else if (wr) begin
            case (sel)
                REG_MSIP:   msip            <= wdata_i[0];
                REG_CMP_LO: mtimecmp[31:0]  <= wdata_i;
                REG_CMP_HI: mtimecmp[63:32] <= wdata_i;
                default:    ;
            endcase
        end
    end

    // Level output: stays high until software moves mtimecmp or mtime.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) timer_irq_o <= 1'b0;
        else       timer_irq_o <= (mtime >= mtimecmp);
    end

endmodule

// File: tb/tb_rv_clint.sv
// Bench for rv_clint: two instances (TICK_DIV 1 and 4) on a shared bus, checked against a
// time-based model where mtime = last loaded value + elapsed cycles / TICK_DIV.
module tb_rv_clint;

    typedef logic [63:0] u64;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        sirq  [2];
    logic        tirq  [2];

    int errors = 0;
    int checks = 0;
    longint cyc;

    // Model: per instance, mtime after edge k = base + (k - eb) / div, with one level of history.
    int     div [2];
    u64     base [2];
    u64     pbase [2];
    longint eb [2];
    longint peb [2];
    u64     cmp_now;
    u64     cmp_old;
    longint cmp_edge;
    bit     msip_m;
    logic [15:0] pool [5];
    vec_t   vecs [16];

    rv_clint #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rstn(rstn), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]), .soft_irq_o(sirq[0]), .timer_irq_o(tirq[0])
    );

    rv_clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rstn(rstn), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]), .soft_irq_o(sirq[1]), .timer_irq_o(tirq[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic u64 mt_at(input int i, input longint k);
        if (k >= eb[i]) return base[i] + u64'((k - eb[i]) / div[i]);
        return pbase[i] + u64'((k - peb[i]) / div[i]);
    endfunction

    function automatic u64 cmp_at(input longint k);
        return (k >= cmp_edge) ? cmp_now : cmp_old;
    endfunction

    function automatic bit valid_addr(input logic [15:0] a);
        return a inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
    endfunction

    function automatic logic [31:0] rd_model(input int i, input logic [15:0] a, input longint c);
        u64 t;
        u64 m;
        t = cmp_at(c);
        m = mt_at(i, c);
        case (a)
            16'h0000: return {31'd0, msip_m};
            16'h4000: return t[31:0];
            16'h4004: return t[63:32];
            16'hBFF8: return m[31:0];
            16'hBFFC: return m[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            base[i] = '0; pbase[i] = '0; eb[i] = 0; peb[i] = 0;
        end
        cmp_now = '1; cmp_old = '1; cmp_edge = 0; msip_m = 1'b0;
    endtask

    // timer_irq at count k reflects the compare on the state after edge k-1.
    task automatic check_irq();
        longint k;
        bit     exp_t;
        k = cyc;
        for (int i = 0; i < 2; i++) begin
            exp_t = (k > 0) && (mt_at(i, k - 1) >= cmp_at(k - 1));
            chk($sformatf("timer_irq[%0d]", i), tirq[i], exp_t);
            chk($sformatf("soft_irq[%0d]", i), sirq[i], msip_m);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_irq();
    endtask

    task automatic access(input bit we, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] r0, output logic [31:0] r1, output logic e0);
        longint      c;
        bit          e;
        u64          old [2];
        logic [31:0] exp_r [2];
        c = cyc;
        e = !valid_addr(a);
        for (int i = 0; i < 2; i++) begin
            old[i]   = mt_at(i, c);
            exp_r[i] = e ? 32'd0 : rd_model(i, a, c);
        end
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
        @(negedge clk);
        req_i = 1'b0;
        if (we && !e) begin
            case (a)
                16'h0000: msip_m = d[0];
                16'h4000: begin cmp_old = cmp_now; cmp_now[31:0]  = d; cmp_edge = c + 1; end
                16'h4004: begin cmp_old = cmp_now; cmp_now[63:32] = d; cmp_edge = c + 1; end
                default: begin
                    for (int i = 0; i < 2; i++) begin
                        pbase[i] = base[i];
                        peb[i]   = eb[i];
                        base[i]  = (a == 16'hBFF8) ? {old[i][63:32], d} : {d, old[i][31:0]};
                        eb[i]    = c + 1;
                    end
                end
            endcase
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ack[%0d] a=%h", i, a), ack[i], 1'b1);
            chk($sformatf("err[%0d] a=%h", i, a), err[i], e);
            if (!we || e) chk($sformatf("rdata[%0d] a=%h", i, a), rdata[i], exp_r[i]);
        end
        r0 = rdata[0]; r1 = rdata[1]; e0 = err[0];
        check_irq();
        step();
        for (int i = 0; i < 2; i++) chk($sformatf("ack_drop[%0d]", i), ack[i], 1'b0);
    endtask

    initial begin
        logic [31:0] r0, r1;
        logic        e0;
        logic [15:0] a;
        int          n;
        int          sel;

        div[0] = 1; div[1] = 4;
        pool = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
        vecs[0]  = '{1'b1, 16'h4004, 32'h0000_0001, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 16'h4000, 32'h89AB_CDEF, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 16'h4000, 32'h0,         1'b0, 1'b1, 32'h89AB_CDEF};
        vecs[3]  = '{1'b0, 16'h4004, 32'h0,         1'b0, 1'b1, 32'h0000_0001};
        vecs[4]  = '{1'b0, 16'h0002, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 16'h1234, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 16'h4002, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 16'h0001, 32'h1,         1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 16'h4000, 32'h0,         1'b0, 1'b1, 32'h89AB_CDEF};
        vecs[10] = '{1'b0, 16'hBFFA, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 16'h8000, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 32'h1};
        vecs[14] = '{1'b1, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 16'h0000, 32'h0,         1'b0, 1'b1, 32'h0};

        // Reset state
        #1 rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst ack", ack[i], 1'b0);
            chk("rst err", err[i], 1'b0);
            chk("rst rdata", rdata[i], 32'h0);
            chk("rst soft_irq", sirq[i], 1'b0);
            chk("rst timer_irq", tirq[i], 1'b0);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();

        // mtime read right after release, then prescaler spacing
        access(1'b0, 16'hBFF8, 32'h0, r0, r1, e0);
        chk("mtime after reset in 0..3", (r0 <= 32'd3), 1'b1);
        repeat (6) step();
        access(1'b0, 16'hBFF8, 32'h0, r0, r1, e0);
        chk("div1 mtime at 8", r0, 32'd8);
        chk("div4 mtime at 8", r1, 32'd2);
        repeat (2) step();
        access(1'b0, 16'hBFF8, 32'h0, r0, r1, e0);
        chk("div1 mtime at 12", r0, 32'd12);
        chk("div4 mtime at 12", r1, 32'd3);

        // Decode, error and msip vectors
        foreach (vecs[v]) begin
            access(vecs[v].we, vecs[v].addr, vecs[v].wdata, r0, r1, e0);
            chk($sformatf("vec%0d err", v), e0, vecs[v].exp_err);
            if (vecs[v].chk_rd) chk($sformatf("vec%0d rdata", v), r0, vecs[v].exp_rd);
            if (vecs[v].we && vecs[v].addr == 16'h0000)
                chk($sformatf("vec%0d soft_irq", v), sirq[0], vecs[v].wdata[0]);
        end

        // req_i held for four cycles: ack on cycles 2 and 4 only
        req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0000;
        for (int j = 1; j <= 4; j++) begin
            step();
            chk($sformatf("held req ack cycle %0d", j + 1), ack[0], (j == 1 || j == 3));
            if (j == 4) req_i = 1'b0;
        end
        step();

        // Timer interrupt rise at mtime == 100 and fall after raising mtimecmp
        access(1'b1, 16'hBFFC, 32'h0, r0, r1, e0);
        access(1'b1, 16'hBFF8, 32'h0, r0, r1, e0);
        access(1'b1, 16'h4004, 32'h0, r0, r1, e0);
        access(1'b1, 16'h4000, 32'd100, r0, r1, e0);
        n = 0;
        while (tirq[0] !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("timer_irq rise within bound", (n < 400), 1'b1);
        access(1'b0, 16'hBFF8, 32'h0, r0, r1, e0);
        chk("mtime one cycle after irq rise", r0, 32'd101);
        access(1'b1, 16'h4000, 32'hFFFF_FFFF, r0, r1, e0);
        chk("timer_irq fall after ack", tirq[0], 1'b0);

        // Wrap-around with mtimecmp all ones
        access(1'b1, 16'h4004, 32'hFFFF_FFFF, r0, r1, e0);
        access(1'b1, 16'hBFFC, 32'hFFFF_FFFF, r0, r1, e0);
        access(1'b1, 16'hBFF8, 32'hFFFF_FFFE, r0, r1, e0);
        chk("wrap irq at FFFE", tirq[0], 1'b0);
        step();
        chk("wrap irq at FFFF", tirq[0], 1'b1);
        step();
        chk("wrap irq after wrap", tirq[0], 1'b0);
        access(1'b0, 16'hBFF8, 32'h0, r0, r1, e0);
        chk("mtime_lo after wrap", r0, 32'd1);
        access(1'b0, 16'hBFFC, 32'h0, r0, r1, e0);
        chk("mtime_hi after wrap", r0, 32'd0);

        // Randomized traffic against the model
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 6);
            if (sel < 5)       a = pool[sel];
            else if (sel == 5) a = 16'($urandom);
            else               a = pool[$urandom_range(0, 4)] | 16'($urandom_range(1, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, r0, r1, e0);
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset during the response of an mtimecmp write aborts it
        req_i = 1'b1; we_i = 1'b1; addr_i = 16'h4000; wdata_i = 32'h1234_5678;
        @(negedge clk);
        req_i = 1'b0;
        chk("abort: in response", ack[0], 1'b1);
        rstn = 1'b0;
        #1;
        chk("abort: ack dropped dut1", ack[0], 1'b0);
        chk("abort: ack dropped dut4", ack[1], 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        step();
        chk("abort: no ack after release", ack[0], 1'b0);
        access(1'b0, 16'h4000, 32'h0, r0, r1, e0);
        chk("abort: mtimecmp_lo all ones", r0, 32'hFFFF_FFFF);
        access(1'b0, 16'h4004, 32'h0, r0, r1, e0);
        chk("abort: mtimecmp_hi all ones", r0, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
